fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core, directly upstream of the decoder and control unit. Holds the PC, issues word requests to instruction memory over a request/grant + response-valid handshake, and buffers returned instructions in a small in-order queue. It presents one instruction per cycle to decode with the opcode/funct3/funct7 fields pre-split for the control unit. A taken branch/jump redirect flushes all fetched and in-flight instructions.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch stage and the control unit.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J     = 7'b1101111;
  localparam logic [6:0] OPC_JR    = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at issue, filled in order by
// memory responses and popped by decode. Flush drops every entry.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_instr,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] unfilled
);

  localparam int PTR_W = $clog2(DEPTH);

  // One extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] alloc_ptr;
  logic [PTR_W:0] fill_ptr;
  logic [PTR_W:0] pop_ptr;
  fetch_entry_t   entries [DEPTH];

  assign count    = alloc_ptr - pop_ptr;
  assign unfilled = alloc_ptr - fill_ptr;
  assign head     = entries[pop_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].pc     <= '0;
        entries[i].instr  <= NOP_INSTR;
        entries[i].filled <= 1'b0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      // alloc, fill and pop always address distinct entries
      if (alloc) begin
        entries[alloc_ptr[PTR_W-1:0]].pc     <= alloc_pc;
        entries[alloc_ptr[PTR_W-1:0]].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr[PTR_W-1:0]].instr  <= fill_instr;
        entries[fill_ptr[PTR_W-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[pop_ptr[PTR_W-1:0]].filled <= 1'b0;
        pop_ptr <= pop_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, imem request/grant/rvalid handshake, and the
// decode-facing head of the fetch queue with pre-split control fields.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  logic [CW:0]     occupancy;
  fetch_entry_t    head;
  logic            issue;
  logic            resp_drop;
  logic            resp_fill;
  logic            pop;

  // Stale in-flight responses still hold a slot until they come back.
  assign occupancy = (CW+1)'(count) + (CW+1)'(discard_cnt);
  assign imem_req  = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;

  assign resp_drop = imem_rvalid && (discard_cnt != '0);
  assign resp_fill = imem_rvalid && (discard_cnt == '0) && (unfilled != '0);
  assign pop       = head.filled && id_ready;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc      (issue),
    .alloc_pc   (pc_q),
    .fill       (resp_fill),
    .fill_instr (imem_rdata),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .unfilled   (unfilled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= word_align(redirect_pc);
    end else if (issue) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // A response landing in the redirect cycle is consumed by that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      discard_cnt <= discard_cnt + unfilled - CW'(resp_drop || resp_fill);
    end else if (resp_drop) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

  assign id_valid  = head.filled;
  assign id_instr  = head.filled ? head.instr : NOP_INSTR;
  assign id_pc     = head.filled ? head.pc : '0;
  assign id_opcode = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based memory and decode model
// predicts requests, addresses and the instruction stream seen by decode.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7      (id_funct7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } pend_t;

  pend_t       pending[$];   // granted requests awaiting a response
  logic [31:0] buffered[$];  // PCs of fetched instructions waiting for decode
  logic [31:0] exp_fetch_pc;
  int          cyc;
  int          n_checks;
  int          n_errors;
  int          p_gnt, p_rv, p_rdy, p_redir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h40B5_0533;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | {28'h0, r[3:0]};
    return r & 32'h0000_03FF;
  endfunction

  task automatic step(input bit force_redir, input logic [31:0] force_pc, input bit spurious);
    bit          resp, exp_req, issue, pop;
    logic [31:0] h;
    pend_t       e;
    @(negedge clk);
    imem_gnt       = pct(p_gnt);
    id_ready       = pct(p_rdy);
    redirect_valid = force_redir || pct(p_redir);
    redirect_pc    = force_redir ? force_pc : rand_target();
    resp = (pending.size() > 0) && (pending[0].cyc < cyc) && pct(p_rv);
    imem_rvalid = resp || spurious;
    imem_rdata  = resp ? mem_word(pending[0].addr) : $urandom;
    #1;
    exp_req = !redirect_valid && (pending.size() + buffered.size() < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_fetch_pc);
    check("id_valid", id_valid, buffered.size() > 0);
    if (buffered.size() > 0) begin
      h = buffered[0];
      check("id_pc", id_pc, h);
      check("id_instr", id_instr, mem_word(h));
      check("id_opcode", id_opcode, {25'h0, mem_word(h) & 32'h7F});
      check("id_funct3", id_funct3, (mem_word(h) >> 12) & 32'h7);
      check("id_funct7", id_funct7, mem_word(h) >> 25);
      if (h == 32'h0000_0200) begin
        check("sub_opcode", id_opcode, 32'h33);
        check("sub_funct3", id_funct3, 32'h0);
        check("sub_funct7", id_funct7, 32'h20);
      end
    end else begin
      check("idle_instr", id_instr, NOP);
      check("idle_pc", id_pc, 32'h0);
    end
    issue = exp_req && imem_gnt;
    pop   = (buffered.size() > 0) && id_ready;
    if (pop) void'(buffered.pop_front());
    if (resp) begin
      e = pending.pop_front();
      if (!e.stale) buffered.push_back(e.addr);
    end
    if (issue) begin
      pending.push_back('{addr: exp_fetch_pc, stale: 1'b0, cyc: cyc});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redirect_valid) begin
      buffered.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic run(input int n, input int g, input int rv, input int rdy, input int rd);
    p_gnt = g; p_rv = rv; p_rdy = rdy; p_redir = rd;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", id_valid, 1'b0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    exp_fetch_pc = RESET_PC;
    p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;

    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // streaming with single-cycle memory
    run(20, 100, 100, 100, 0);
    // decode stall fills the queue, then drains in order
    run(10, 100, 100, 0, 0);
    run(10, 100, 100, 100, 0);
    // two requests in flight when redirecting to an unaligned target
    run(6, 0, 100, 100, 0);
    run(2, 100, 0, 100, 0);
    p_rv = 0;
    step(1'b1, 32'h0000_0103, 1'b0);
    run(12, 100, 100, 100, 0);
    // grant withheld
    run(3, 0, 100, 100, 0);
    run(5, 100, 100, 100, 0);
    // redirect coinciding with a response and a pop
    run(2, 100, 100, 100, 0);
    p_gnt = 100; p_rv = 100; p_rdy = 100;
    step(1'b1, 32'h0000_0200, 1'b0);
    run(12, 100, 100, 100, 0);
    // random traffic, including redirects near the top of the address space
    run(1500, 70, 60, 70, 3);
    run(300, 90, 30, 40, 2);

    // reset mid-operation, then a response with nothing outstanding
    @(negedge clk);
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    #1 check_reset_outputs();
    pending.delete();
    buffered.delete();
    exp_fetch_pc = RESET_PC;
    @(posedge clk);
    #2 rst_n = 1'b1;
    p_gnt = 100; p_rv = 0; p_rdy = 100; p_redir = 0;
    step(1'b0, 32'h0, 1'b1);
    run(300, 75, 65, 75, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
